// File: rtl/fetch_cycle_if.sv
`default_nettype none
// ============================================================
// fetch_cycle_if: instruction-memory read/busywait bus
// Revision: 1.0
// ============================================================
interface fetch_cycle_if;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_busywait;

  modport master (
    output imem_read,
    output imem_addr,
    input  imem_rdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_read,
    input  imem_addr,
    output imem_rdata,
    output imem_busywait
  );
endinterface
`default_nettype wire

// File: rtl/fetch_cycle.sv
`default_nettype none
// ============================================================
// fetch_cycle: RV32 IF stage - PC, imem handshake, IF/ID register, skid buffer
// Revision: 1.0
// ============================================================
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        StallD,
  input  wire logic        PCSelectE,
  input  wire logic [31:0] PCTargetE,
  fetch_cycle_if.master    imem,
  output logic [31:0]      instructionF,
  output logic [31:0]      PCF,
  output logic             validF
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcF;
  logic        r_valid;
  logic [31:0] r_skidInstr;
  logic [31:0] r_skidPc;
  logic [31:0] r_redirectTarget;
  logic        r_redirectPending;

  logic [31:0] w_target;
  logic        w_complete;
  logic        w_flush;
  logic        w_bubble;
  logic        w_loadFetch;
  logic        w_loadSkid;
  logic        w_unloadSkid;
  logic        w_pcInc;
  logic        w_pcToTarget;
  logic        w_pcToPending;
  logic        w_latchRedirect;

  assign w_target   = {PCTargetE[31:2], 2'b00};
  assign w_complete = (r_state == FETCH) && !imem.imem_busywait;

  assign imem.imem_read = (r_state == FETCH) && !reset;
  assign imem.imem_addr = r_pc;

  assign instructionF = r_instr;
  assign PCF          = r_pcF;
  assign validF       = r_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext     = r_state;
    w_flush         = 1'b0;
    w_bubble        = 1'b0;
    w_loadFetch     = 1'b0;
    w_loadSkid      = 1'b0;
    w_unloadSkid    = 1'b0;
    w_pcInc         = 1'b0;
    w_pcToTarget    = 1'b0;
    w_pcToPending   = 1'b0;
    w_latchRedirect = 1'b0;

    if (PCSelectE) begin
      // An access still waiting on memory cannot be cancelled, so park the target.
      w_flush     = 1'b1;
      w_stateNext = FETCH;
      if ((r_state == HOLD) || w_complete) begin
        w_pcToTarget = 1'b1;
      end else begin
        w_latchRedirect = 1'b1;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_complete) begin
            if (r_redirectPending) begin
              w_pcToPending = 1'b1;
            end else if (StallD) begin
              w_loadSkid  = 1'b1;
              w_pcInc     = 1'b1;
              w_stateNext = HOLD;
            end else begin
              w_loadFetch = 1'b1;
              w_pcInc     = 1'b1;
            end
          end else if (!StallD) begin
            w_bubble = 1'b1;
          end
        end
        HOLD: begin
          if (!StallD) begin
            w_unloadSkid = 1'b1;
            w_stateNext  = FETCH;
          end
        end
        default: w_stateNext = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc              <= RESET_PC;
      r_instr           <= NOP_INSTR;
      r_pcF             <= RESET_PC;
      r_valid           <= 1'b0;
      r_skidInstr       <= NOP_INSTR;
      r_skidPc          <= RESET_PC;
      r_redirectTarget  <= RESET_PC;
      r_redirectPending <= 1'b0;
    end else begin
      if (w_pcToTarget) begin
        r_pc <= w_target;
      end else if (w_pcToPending) begin
        r_pc <= r_redirectTarget;
      end else if (w_pcInc) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_latchRedirect) begin
        r_redirectTarget  <= w_target;
        r_redirectPending <= 1'b1;
      end else if (w_pcToTarget || w_pcToPending) begin
        r_redirectPending <= 1'b0;
      end

      if (w_loadSkid) begin
        r_skidInstr <= imem.imem_rdata;
        r_skidPc    <= r_pc;
      end

      if (w_flush || w_bubble) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end else if (w_loadFetch) begin
        r_instr <= imem.imem_rdata;
        r_pcF   <= r_pc;
        r_valid <= 1'b1;
      end else if (w_unloadSkid) begin
        r_instr <= r_skidInstr;
        r_pcF   <= r_skidPc;
        r_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
